// File: rtl/control_sequencer_if.sv
// Mini SRC control bundle: opcode/condition/memory/stop inputs to the sequencer
// and every datapath strobe it drives back out.
interface control_sequencer_if;
  logic [4:0] op;
  logic       con_ff;
  logic       mem_ready;
  logic       stop;
  logic       PCout, Zlowout, MDRout, Cout;
  logic       MARin, PCin, MDRin, IRin, Yin, Zin, CONin;
  logic       IncPC, Read, Write;
  logic       Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] alu_op;
  logic       run;

  modport master (
    input  op, con_ff, mem_ready, stop,
    output PCout, Zlowout, MDRout, Cout,
    output MARin, PCin, MDRin, IRin, Yin, Zin, CONin,
    output IncPC, Read, Write,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output alu_op, run
  );

  modport slave (
    output op, con_ff, mem_ready, stop,
    input  PCout, Zlowout, MDRout, Cout,
    input  MARin, PCin, MDRin, IRin, Yin, Zin, CONin,
    input  IncPC, Read, Write,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  alu_op, run
  );
endinterface

// File: rtl/control_sequencer.sv
// Mini SRC multi-cycle control FSM: fetch, decode, per-class execute steps,
// memory stalls and halt/stop handling. All strobes are Moore outputs.
module control_sequencer #(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input logic                  clock,
  input logic                  reset,
  control_sequencer_if.master  bus
);
  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010, OP_ADDI = 5'b01011, OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101, OP_BR   = 5'b10010, OP_JR   = 5'b10011;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {C_R, C_I, C_LDI, C_LD, C_ST, C_BR, C_JR} class_t;

  state_t state_q, state_d;
  class_t class_q, class_d;
  class_t dec_class;
  logic   dec_ok;
  logic   done;

  // Undefined opcodes (and nop) leave dec_ok low and retire straight from F2.
  always_comb begin
    dec_ok    = 1'b1;
    dec_class = C_R;
    case (bus.op)
      OP_LD:                          dec_class = C_LD;
      OP_LDI:                         dec_class = C_LDI;
      OP_ST:                          dec_class = C_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR:  dec_class = C_R;
      OP_ADDI, OP_ANDI, OP_ORI:       dec_class = C_I;
      OP_BR:                          dec_class = C_BR;
      OP_JR:                          dec_class = C_JR;
      default:                        dec_ok    = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    done    = 1'b0;
    case (state_q)
      S_RST: state_d = S_F0;
      S_F0:  state_d = S_F1;
      S_F1:  if (bus.mem_ready) state_d = S_F2;
      S_F2: begin
        if (bus.op == OP_HALT) begin
          state_d = S_HALT;
        end else if (dec_ok) begin
          class_d = dec_class;
          state_d = S_T3;
        end else begin
          done = 1'b1;
        end
      end
      S_T3:  if (class_q == C_JR) done = 1'b1; else state_d = S_T4;
      S_T4:  state_d = S_T5;
      S_T5:  if (class_q inside {C_R, C_I, C_LDI}) done = 1'b1; else state_d = S_T6;
      S_T6: begin
        case (class_q)
          C_LD:    if (bus.mem_ready) state_d = S_T7;
          C_ST:    state_d = S_T7;
          default: done = 1'b1;
        endcase
      end
      S_T7:  if (!(class_q == C_ST && !bus.mem_ready)) done = 1'b1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    // stop only takes effect on the edge that retires an instruction
    if (done) state_d = bus.stop ? S_HALT : S_F0;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    class_q <= class_d;
  end

  always_comb begin
    bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.MDRout = 1'b0; bus.Cout = 1'b0;
    bus.MARin = 1'b0; bus.PCin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0;
    bus.Yin = 1'b0; bus.Zin = 1'b0; bus.CONin = 1'b0;
    bus.IncPC = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
    bus.Rin = 1'b0; bus.Rout = 1'b0; bus.BAout = 1'b0;
    bus.alu_op = 5'd0;
    bus.run = (state_q != S_RST) && (state_q != S_HALT);
    case (state_q)
      S_F0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
      S_F1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
      S_F2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      S_T3: begin
        case (class_q)
          C_R, C_I:          begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
          C_LDI, C_LD, C_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
          C_BR:              begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
          C_JR:              begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (class_q)
          C_R:               begin bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = bus.op; end
          C_I:               begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = bus.op; end
          C_LDI, C_LD, C_ST: begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = ADD_OP; end
          C_BR:              begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (class_q)
          C_R, C_I, C_LDI: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          C_LD, C_ST:      begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
          C_BR:            begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = ADD_OP; end
          default: ;
        endcase
      end
      S_T6: begin
        case (class_q)
          C_LD: begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
          C_ST: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
          C_BR: begin bus.Zlowout = bus.con_ff; bus.PCin = bus.con_ff; end
          default: ;
        endcase
      end
      S_T7: begin
        case (class_q)
          C_LD:    begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          C_ST:    bus.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control FSM for the Mini SRC datapath.
- Consumes the 5-bit opcode decoded from the IR and the CON FF branch result.
- Drives the datapath strobes, including Gra/Grb/Grc/Rin/Rout/BAout, which feed the register select/encode logic directly downstream.
- Sequences fetch, decode and per-class execute steps, with memory handshake stalls and a halt/stop mechanism.

Parameters:
ADD_OP, 5'b00011, ALU code used for address and branch-target arithmetic

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high; forces state RST
op  input  5  opcode from IR[31:27]
con_ff  input  1  branch condition flip-flop output
mem_ready  input  1  memory completes the current Read/Write this cycle
stop  input  1  level request: finish current instruction, then halt
PCout, Zlowout, MDRout, Cout  output  1 each  bus drive strobes
MARin, PCin, MDRin, IRin, Yin, Zin, CONin  output  1 each  register load strobes
IncPC, Read, Write  output  1 each  PC increment, memory read, memory write
Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-field select and register enable/drive to the select/encode stage
alu_op  output  5  ALU operation select
run  output  1  high while executing, low in RST and HALTED

Behaviour:
- Moore outputs: every output is a function of state, plus op where noted. Unlisted outputs are 0 in each state.
- Reset: the next edge enters RST, with all outputs 0 and alu_op=0. Reset mid-instruction aborts with no completion. RST always goes to F0 on the next edge with run=1.
- Fetch:
  - F0: PCout, MARin, IncPC, Zin.
  - F1: Zlowout, PCin, Read, MDRin. Holds while mem_ready=0.
  - F2: MDRout, IRin. Next state is chosen by op.
- Opcode classes (others decode as nop):
  - ld=00000, ldi=00001, st=00010
  - R-type add/sub/and/or = 00011/00100/01001/01010
  - I-type addi/andi/ori = 01011/01100/01101
  - br=10010, jr=10011, nop=11001, halt=11010
- R-type:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=op.
  - T5: Zlowout, Gra, Rin.
- I-type: same as R-type, except T4 uses Cout in place of Grc/Rout.
- ldi: T3 Grb, BAout, Yin. T4 Cout, Zin, alu_op=ADD_OP. T5 Zlowout, Gra, Rin.
- ld: T3–T4 as ldi, then:
  - T5: Zlowout, MARin.
  - T6: Read, MDRin. Holds until mem_ready.
  - T7: MDRout, Gra, Rin.
- st: T3–T5 as ld, then:
  - T6: Gra, Rout, MDRin (Read=0).
  - T7: Write. Holds until mem_ready.
- br:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zin, alu_op=ADD_OP.
  - T6: Zlowout and PCin only if con_ff=1. con_ff is sampled in T6.
- jr: T3 Gra, Rout, PCin.
- nop: F2 goes directly to F0.
- halt: F2 goes to HALTED. run=0, all strobes 0. Only reset exits.
- Instruction end: after the last step of any instruction, go to F0, or to HALTED if stop=1 on that edge. stop is ignored mid-instruction.
- Mutual exclusion: at most one bus-drive strobe (PCout, Zlowout, MDRout, Cout, Rout) is high in any cycle. Gra/Grb/Grc are mutually exclusive. Read and Write are never both high.
- Stalls: while stalled, all strobes of the stall state stay asserted unchanged. A reset during a stall wins.
- Latency (mem_ready tied 1):
  - R-type, I-type, ldi: 6 cycles.
  - ld, st: 8 cycles.
  - br: 7 cycles.
  - jr: 4 cycles.
  - nop: 3 cycles.

Test Plan:
- Reset: assert reset 2 cycles, release → RST for 1 cycle (all 0), then F0 with PCout=MARin=IncPC=Zin=1 and run=1.
- add (op=00011), mem_ready=1 → F0..T5 in 6 cycles. T4 shows Grc=Rout=Zin=1 and alu_op=00011. T5 shows Gra=Rin=1. Next edge is F0.
- ld (op=00000), mem_ready low 3 cycles in T6 → T6 held exactly 3 extra cycles with Read=MDRin=1. T3 shows BAout=Grb=1. T7 shows MDRout=Gra=Rin=1.
- br (op=10010): with con_ff=0, T6 has PCin=0. With con_ff=1, T6 has Zlowout=PCin=1. Both take 7 cycles.
- stop: raise stop during T4 of addi → instruction completes through T5, then HALTED with run=0. halt (op=11010) also goes to HALTED; only reset returns to RST.
- Reset during st T7 stall (mem_ready=0) → next edge in RST, Write=0.
